// File: rtl/rupt_priority_scheduler.sv
// Fixed-priority program-interrupt scheduler: latches rupt requests, arbitrates, hands the vector to the sequencer.
// Optional RUPT LOCK watchdog is enabled by defining RUPT_LOCK_ALARM_EN.
module rupt_priority_scheduler #(
  parameter int unsigned NSRC       = 10,
  parameter logic [11:0] VEC_BASE   = 12'o4004,
  parameter int unsigned VEC_STRIDE = 4,
  parameter logic [15:0] LOCK_LIMIT = 16'd8192
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            gojam,
  input  logic [NSRC-1:0] rpt_in,
  input  logic            inhint,
  input  logic            ovf,
  input  logic            extend,
  input  logic            rupt_ack,
  input  logic            resume,
  output logic            rupt_req,
  output logic [11:0]     rupt_vec,
  output logic [3:0]      rupt_idx,
  output logic            in_isr,
  output logic [NSRC-1:0] pending,
  output logic            rupt_lock
);

  typedef enum logic [1:0] {StIdle, StReq, StIsr} state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [3:0]      idx_q, idx_d;
  logic [11:0]     vec_q, vec_d;
  logic [3:0]      win_idx;
  logic            blocked;

  assign blocked = inhint | ovf | extend;

  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_q[i]) win_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (|pend_q && !blocked) begin
          state_d = StReq;
          idx_d   = win_idx;
          vec_d   = VEC_BASE + 12'(VEC_STRIDE * 32'(win_idx));
        end
      end
      StReq: begin
        if (rupt_ack) begin
          state_d = StIsr;
          pend_d  = pend_q & ~(NSRC'(1) << idx_q);
        end else if (blocked) begin
          state_d = StIdle;
        end
      end
      StIsr: begin
        if (resume) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // New requests are OR'd in last so a set always beats a same-cycle clear.
    pend_d = pend_d | rpt_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
    end else if (gojam) begin
      state_q <= StIdle;
      pend_q  <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  assign rupt_req = (state_q == StReq);
  assign in_isr   = (state_q == StIsr);
  assign rupt_idx = idx_q;
  assign rupt_vec = vec_q;
  assign pending  = pend_q;

`ifdef RUPT_LOCK_ALARM_EN
  logic [15:0] lock_cnt_q;
  logic        lock_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else if (gojam) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      if (state_q != StIsr) begin
        lock_cnt_q <= '0;
      end else if (lock_cnt_q != LOCK_LIMIT) begin
        lock_cnt_q <= lock_cnt_q + 16'd1;
      end
      // Fires once, on the step that brings the count to the limit.
      lock_q <= (state_q == StIsr) && (lock_cnt_q == LOCK_LIMIT - 16'd1);
    end
  end

  assign rupt_lock = lock_q;
`else
  logic unused_lock_limit;
  assign unused_lock_limit = ^LOCK_LIMIT;
  assign rupt_lock         = 1'b0;
`endif

endmodule
